// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline sequencer state and register-index width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  // A load targeting $zero never produces a value anyone waits for.
  assign load_use = idex_dREN && (idex_wsel != '0) &&
                    ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage core: latch enables, bubble inserts,
// dcache request gating, halt drain and a saturating stall-cycle counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             mem_redirect,
  input  logic             idex_dREN,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state, next_state;
  logic   load_use;
  logic   dwait;

  hazard_detect u_hazard (
    .idex_dREN (idex_dREN),
    .idex_wsel (idex_wsel),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .load_use  (load_use)
  );

  assign dwait = (mem_dREN || mem_dWEN) && !dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (!pc_en && (state != HALTED) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state)
      RUN: begin
        if (dwait) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (mem_halt) begin
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          next_state  = DRAIN;
        end else if (mem_redirect) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b1;
        next_state  = HALTED;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        if (state != HALTED) next_state = RUN;
      end
    endcase
    // Hold every latch still while reset is asserted.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  assign dmem_ren = mem_dREN && (state == RUN) && nRST;
  assign dmem_wen = mem_dWEN && (state == RUN) && nRST;
  assign halt     = (state == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: fixed vectors, directed multi-cycle sequences and
// randomized traffic against a reference model; a CNT_W=4 copy covers saturation.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       mhalt;
    logic       redir;
    logic       ldr;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [11:0] exp;
    logic [11:0] msk;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_redirect, idex_dREN;
  logic [4:0] idex_wsel, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic dmem_ren, dmem_wen, halt;
  logic [15:0] stall_cnt;
  logic q_pc_en, q_ifid_en, q_idex_en, q_exmem_en, q_memwb_en;
  logic q_ifid_flush, q_idex_flush, q_exmem_flush, q_memwb_flush;
  logic q_dmem_ren, q_dmem_wen, q_halt;
  logic [3:0] q_stall_cnt;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .mem_redirect(mem_redirect), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .halt(halt), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .mem_redirect(mem_redirect), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(q_pc_en), .ifid_en(q_ifid_en), .idex_en(q_idex_en), .exmem_en(q_exmem_en),
    .memwb_en(q_memwb_en), .ifid_flush(q_ifid_flush), .idex_flush(q_idex_flush),
    .exmem_flush(q_exmem_flush), .memwb_flush(q_memwb_flush),
    .dmem_ren(q_dmem_ren), .dmem_wen(q_dmem_wen), .halt(q_halt), .stall_cnt(q_stall_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ph = 0;                 // 0 running, 1 draining, 2 halted
  int unsigned cnt16 = 0;
  int unsigned cnt4  = 0;

  // Output bit order: pc ifid idex exmem memwb | ifid_f idex_f exmem_f memwb_f | ren wen halt
  function automatic logic [11:0] act();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush,
            dmem_ren, dmem_wen, halt};
  endfunction

  function automatic logic [11:0] act4();
    return {q_pc_en, q_ifid_en, q_idex_en, q_exmem_en, q_memwb_en,
            q_ifid_flush, q_idex_flush, q_exmem_flush, q_memwb_flush,
            q_dmem_ren, q_dmem_wen, q_halt};
  endfunction

  function automatic in_t mk(logic ih, logic dh, logic dr, logic dw, logic mh,
                             logic rd, logic lr, int ws, int s, int t);
    in_t x;
    x.ihit = ih; x.dhit = dh; x.dren = dr; x.dwen = dw; x.mhalt = mh;
    x.redir = rd; x.ldr = lr;
    x.wsel = 5'(ws); x.rs = 5'(s); x.rt = 5'(t);
    return x;
  endfunction

  // Expected outputs; mask clears the enables of latches that are being flushed
  // (flush overrides enable) and memwb_en while memwb is flushed by a dcache wait.
  function automatic void model(input int p, input logic rn, input in_t x,
                                output logic [11:0] v, output logic [11:0] m);
    logic luse, dw;
    v = '0;
    m = 12'hFFF;
    luse = x.ldr && (x.wsel != 0) && (x.wsel == x.rs || x.wsel == x.rt);
    dw   = (x.dren || x.dwen) && !x.dhit;
    if (!rn) return;
    if (p == 2) begin v[0] = 1'b1; return; end
    if (p == 1) begin v[3] = 1'b1; return; end
    v[2] = x.dren;
    v[1] = x.dwen;
    if (dw) begin
      v[3] = 1'b1; m[7] = 1'b0;
    end else if (x.mhalt) begin
      v[7] = 1'b1; v[6:4] = 3'b111; m[10:8] = 3'b000;
    end else if (x.redir) begin
      v[11] = 1'b1; v[7] = 1'b1; v[6:4] = 3'b111; m[10:8] = 3'b000;
    end else if (luse) begin
      v[8] = 1'b1; v[7] = 1'b1; v[5] = 1'b1; m[9] = 1'b0;
    end else if (!x.ihit) begin
      v[9:7] = 3'b111; v[6] = 1'b1; m[10] = 1'b0;
    end else begin
      v[11:7] = 5'b11111;
    end
  endfunction

  task automatic chk(string nm, logic [11:0] a, logic [11:0] v, logic [11:0] m);
    checks++;
    if ((a & m) !== (v & m)) begin
      errors++;
      $display("FAIL %s outputs got %03h want %03h (mask %03h) t=%0t", nm, a, v, m, $time);
    end
  endtask

  task automatic chk_cnt(string nm, int unsigned a, int unsigned w);
    checks++;
    if (a != w) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d want %0d t=%0t", nm, a, w, $time);
    end
  endtask

  task automatic apply(in_t x);
    ihit = x.ihit; dhit = x.dhit; mem_dREN = x.dren; mem_dWEN = x.dwen;
    mem_halt = x.mhalt; mem_redirect = x.redir; idex_dREN = x.ldr;
    idex_wsel = x.wsel; ifid_rs = x.rs; ifid_rt = x.rt;
  endtask

  task automatic do_reset(string nm);
    nRST = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ph = 0; cnt16 = 0; cnt4 = 0;
    @(negedge CLK);
    chk({nm, "_rst_out"}, act(), 12'h000, 12'hFFF);
    chk_cnt({nm, "_rst_cnt"}, stall_cnt, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic cycle(string nm, in_t x);
    logic [11:0] v, m;
    apply(x);
    @(negedge CLK);
    model(ph, nRST, x, v, m);
    chk(nm, act(), v, m);
    chk({nm, "_w4"}, act4(), v, m);
    chk_cnt({nm, "_c16"}, stall_cnt, cnt16);
    chk_cnt({nm, "_c4"}, q_stall_cnt, cnt4);
    @(posedge CLK);
    if (nRST) begin
      if (ph != 2 && !v[11]) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (ph == 1) ph = 2;
      else if (ph == 0 && x.mhalt && !((x.dren || x.dwen) && !x.dhit)) ph = 1;
    end
    #1;
  endtask

  vec_t vecs[13];
  in_t  idle;

  initial begin
    nRST = 1'b0;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);

    vecs[0]  = '{"normal",       mk(1,0,0,0,0,0,0,0,0,0),  12'hF80, 12'hFFF};
    vecs[1]  = '{"fetch_wait",   mk(0,0,0,0,0,0,0,0,0,0),  12'h3C0, 12'hBFF};
    vecs[2]  = '{"lduse_rt",     mk(1,0,0,0,0,0,1,5,1,5),  12'h1A0, 12'hDFF};
    vecs[3]  = '{"lduse_rs",     mk(1,0,0,0,0,0,1,7,7,2),  12'h1A0, 12'hDFF};
    vecs[4]  = '{"lduse_zero",   mk(1,0,0,0,0,0,1,0,0,0),  12'hF80, 12'hFFF};
    vecs[5]  = '{"no_load",      mk(1,0,0,0,0,0,0,5,5,5),  12'hF80, 12'hFFF};
    vecs[6]  = '{"dwait_rd",     mk(1,0,1,0,0,0,0,0,0,0),  12'h00C, 12'hF7F};
    vecs[7]  = '{"dwait_wr",     mk(1,0,0,1,0,0,0,0,0,0),  12'h00A, 12'hF7F};
    vecs[8]  = '{"dhit_rd",      mk(1,1,1,0,0,0,0,0,0,0),  12'hF84, 12'hFFF};
    vecs[9]  = '{"redir_lduse",  mk(1,0,0,0,0,1,1,5,1,5),  12'h8F0, 12'h8FF};
    vecs[10] = '{"halt",         mk(1,0,0,0,1,0,0,0,0,0),  12'h0F0, 12'h8FF};
    vecs[11] = '{"halt_dwait",   mk(1,0,1,0,1,0,0,0,0,0),  12'h00C, 12'hF7F};
    vecs[12] = '{"redir_nofetch",mk(0,0,0,0,0,1,0,0,0,0),  12'h8F0, 12'h8FF};

    for (int i = 0; i < 13; i++) begin
      do_reset(vecs[i].name);
      apply(vecs[i].in);
      @(negedge CLK);
      chk(vecs[i].name, act(), vecs[i].exp, vecs[i].msk);
      @(posedge CLK);
      #1;
    end

    // Release from reset: everything flows the first cycle.
    do_reset("rel");
    cycle("rel_run", idle);
    chk("rel_fixed", act(), 12'hF80, 12'hFFF);

    // Four-cycle dcache wait, then hit.
    do_reset("dw");
    for (int i = 0; i < 4; i++) cycle("dw_wait", mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    chk_cnt("dw_cnt4", stall_cnt, 4);
    chk("dw_release", act(), 12'hF84, 12'hFFF);
    @(posedge CLK);
    #1;

    // Load-use bubble lasts one cycle once the hazard clears.
    do_reset("lu");
    cycle("lu_stall", mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 5));
    cycle("lu_clear", idle);
    chk_cnt("lu_cnt1", stall_cnt, 1);

    // Halt drain, then reset recovery.
    do_reset("hd");
    cycle("hd_halt", mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    chk("hd_drain", act(), 12'h008, 12'hFFF);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("hd_halted", act(), 12'h001, 12'hFFF);
    chk_cnt("hd_cnt", stall_cnt, 2);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk_cnt("hd_cnt_hold", stall_cnt, 2);
    do_reset("hd_rst");
    ph = 0;
    cycle("hd_after", idle);
    chk("hd_after_fixed", act(), 12'hF80, 12'hFFF);

    // Reset in the middle of a drain.
    do_reset("md");
    cycle("md_halt", mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    do_reset("md_rst");
    cycle("md_run", idle);

    // Saturation of the narrow counter.
    do_reset("sat");
    for (int i = 0; i < 20; i++) cycle("sat_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    chk_cnt("sat_cnt4", q_stall_cnt, 15);
    chk_cnt("sat_cnt16", stall_cnt, 20);
    @(posedge CLK);
    #1;

    // Randomized traffic.
    do_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      in_t x;
      if ((ph == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end
      x.ihit  = ($urandom_range(0, 3) != 0);
      x.dhit  = $urandom_range(0, 1) == 1;
      x.dren  = ($urandom_range(0, 3) == 0);
      x.dwen  = ($urandom_range(0, 5) == 0);
      x.mhalt = ($urandom_range(0, 59) == 0);
      x.redir = ($urandom_range(0, 7) == 0);
      x.ldr   = $urandom_range(0, 1) == 1;
      x.wsel  = 5'($urandom_range(0, 3));
      x.rs    = 5'($urandom_range(0, 3));
      x.rt    = 5'($urandom_range(0, 3));
      cycle("rnd", x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
